// File: rtl/add_sched_pkg.sv
// rtl/add_sched_pkg.sv - shared types and defaults for the shared-adder scheduler
package add_sched_pkg;

    localparam int W_DEF    = 12;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [W_DEF-1:0]            data;
        logic [$clog2(NREQ_DEF)-1:0] id;
    } rsp_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant, searching from one above the last grant
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         grant
);

    // Each requester's distance from the search start; the smallest requesting distance wins.
    int best;

    always_comb begin
        best  = NREQ;
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (((i + NREQ - int'(last) - 1) % NREQ) < best))
                best = (i + NREQ - int'(last) - 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && (((i + NREQ - int'(last) - 1) % NREQ) == best))
                grant[i] = 1'b1;
        end
    end

endmodule

// File: rtl/add_share_sched.sv
// rtl/add_share_sched.sv - schedules NREQ requesters onto one shared two-stage registered adder
module add_share_sched
    import add_sched_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic                    add_start,
    output logic [W-1:0]            add_a,
    output logic [W-1:0]            add_b,
    input  logic [W-1:0]            add_y,
    input  logic                    add_valid,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W-1:0]            rsp_data,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    err
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    logic [IW-1:0]   rr_ptr, rr_last, gnt_id, cur_id, id1, id2;
    logic [NREQ-1:0] gnt;
    logic            v1, v2;
    logic [1:0]      count;
    logic            rd_ptr, wr_ptr;
    logic [W-1:0]    f_data [2];
    logic [IW-1:0]   f_id   [2];
    logic            push, pop, can_grant;
    logic [2:0]      used;

    assign pop  = (count != 2'd0) && rsp_ready;
    assign push = add_valid && v2;

    // A pop in the grant cycle frees its slot early so back-to-back issues stay 2 cycles apart.
    assign used      = {1'b0, count} + {2'b0, v1} + {2'b0, v2} - {2'b0, pop};
    assign can_grant = (state != ISSUE) && (|req_valid) && (used < 3'd2);

    assign rr_last = (rr_ptr == '0) ? IW'(NREQ - 1) : rr_ptr - 1'b1;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .last  (rr_last),
        .grant (gnt)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) gnt_id = IW'(i);
    end

    assign req_ready = (can_grant && rst_n) ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            add_start <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            cur_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (can_grant) begin
                        state     <= ISSUE;
                        add_start <= 1'b1;
                        add_a     <= req_a[int'(gnt_id)*W +: W];
                        add_b     <= req_b[int'(gnt_id)*W +: W];
                        cur_id    <= gnt_id;
                        rr_ptr    <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                    end else begin
                        state     <= IDLE;
                        add_start <= 1'b0;
                    end
                end
                ISSUE: begin
                    state     <= HOLD;
                    add_start <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    add_start <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipeline: v2/id2 line up with the cycle the adder result is due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            id1    <= '0;
            id2    <= '0;
            err    <= 1'b0;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            v1  <= (state == ISSUE);
            id1 <= cur_id;
            v2  <= v1;
            id2 <= id1;
            if (add_valid != v2)
                err <= 1'b1;
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_data[wr_ptr] <= add_y;
            f_id[wr_ptr]   <= id2;
        end
    end

    assign rsp_valid = (count != 2'd0);
    assign rsp_data  = f_data[rd_ptr];
    assign rsp_id    = f_id[rd_ptr];

endmodule

// File: doc/add_share_sched.md
ADD_SHARE_SCHED -- requirements
Module: add_share_sched

Interface
REQ-001 The block SHALL have parameter W, default 12, meaning operand/result width.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-003 Port clk  input  1  the single clock; all flops on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port req_valid  input  NREQ  per-requester operation request.
REQ-006 Port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 Port req_a  input  NREQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-008 Port req_b  input  NREQ*W  packed operand B, same packing.
REQ-009 Port add_start  output  1  start strobe to the shared registered adder.
REQ-010 Port add_a  output  W  operand A to the adder.
REQ-011 Port add_b  output  W  operand B to the adder.
REQ-012 Port add_y  input  W  adder result.
REQ-013 Port add_valid  input  1  adder result valid.
REQ-014 Port rsp_valid  output  1  response available.
REQ-015 Port rsp_ready  input  1  response consumer accept.
REQ-016 Port rsp_data  output  W  sum, modulo 2^W.
REQ-017 Port rsp_id  output  $clog2(NREQ)  index of the originating requester.
REQ-018 Port err  output  1  sticky protocol error flag.

Function
REQ-019 Adder contract: it samples add_a in the add_start cycle (T), samples add_b in cycle T+1, and presents add_y with add_valid=1 in cycle T+2.
REQ-020 FSM states: IDLE, ISSUE, HOLD.
- IDLE -> ISSUE when any req_valid is high and credit > 0.
- ISSUE -> HOLD unconditionally.
- HOLD -> ISSUE if a request is pending and credit > 0; otherwise HOLD -> IDLE.
REQ-021 Grant: the requester is chosen round-robin, starting the search one index above the last granted requester (index 0 first after reset); the grant is evaluated in the IDLE or HOLD cycle that precedes ISSUE.
REQ-022 The granted requester's req_ready SHALL be high in the cycle preceding ISSUE, and its operands SHALL be captured on that edge; req_ready SHALL be low in all other cycles.
REQ-023 In ISSUE: add_start=1, add_a=captured A, add_b=captured B.
REQ-024 In HOLD: add_start=0 and add_b=captured B, held stable.
REQ-025 In IDLE: add_start=0, and add_a/add_b keep their last values.
REQ-026 Throughput: at most one issue per 2 cycles; a new ISSUE may coincide with the T+2 capture of the previous operation.
REQ-027 In-flight tag: the requester id SHALL travel through a 2-stage shift, aligned so that it is present when add_valid is expected.
REQ-028 Response FIFO: depth 2, holding {data, id}; it is pushed on add_valid and popped on rsp_valid && rsp_ready; a simultaneous push and pop at full is legal.
REQ-029 Credit = 2 - (FIFO occupancy + in-flight count); ISSUE SHALL never occur at credit 0, so the FIFO never overflows.
REQ-030 rsp_valid = FIFO non-empty; rsp_data and rsp_id SHALL be driven from the FIFO head and be stable while rsp_valid && !rsp_ready.
REQ-031 err SHALL set when add_valid arrives with no operation in flight, or when an expected add_valid is absent; err stays set until reset.
REQ-032 Withdrawal: a requester may drop req_valid before it is granted; no grant SHALL go to a requester whose req_valid is low.

Reset
REQ-033 Asserting rst_n low SHALL immediately, at any time including mid-operation, set FSM=IDLE, req_ready=0, add_start=0, add_a=0, add_b=0, rsp_valid=0, err=0, FIFO empty, in-flight tags cleared, and round-robin pointer=0.
REQ-034 Operations in flight at reset are discarded; no response SHALL be produced for them.

Structure
REQ-035 A shared package add_sched_pkg SHALL hold the FSM state enum, default W/NREQ constants and the response entry struct {data, id}.
REQ-036 The round-robin grant logic SHALL be a sub-module rr_arbiter (parameter NREQ; inputs req and last-grant; output one-hot grant).

Verification
REQ-037 Single request: req0 with a=12'h005, b=12'h003 -> add_start pulses once, add_b is held for 2 cycles, rsp_data=12'h008 and rsp_id=0 three cycles after the grant.
REQ-038 Wrap-around: a=12'hFFF, b=12'h002 -> rsp_data=12'h001.
REQ-039 All 4 requesters valid continuously -> grant order 0,1,2,3,0, issues spaced exactly 2 cycles apart, and each rsp_id matches its operands.
REQ-040 rsp_ready held low with requests pending -> exactly 2 responses buffered, no further add_start; issue resumes on the first pop.
REQ-041 rst_n asserted in HOLD -> all outputs at reset values in the same cycle, and no response appears after release.
REQ-042 add_valid forced high while idle -> err=1 and remains set until reset.
